delay_mem_arb: RTL and testbench

//  Arbitrates and sequences the delay line's write and read traffic onto the single
//  s2a port of the SDRAM memory controller (mem_write/mem_read/.../mem_readdone).

---
 rtl/theremin_pkg.sv | 28 ++
 rtl/delay_mem_arb_arb2_rr.sv | 53 +++++
 rtl/delay_mem_arb.sv | 168 ++++++++++++++++
 tb/tb_delay_mem_arb.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/theremin_pkg.sv
// Shared types for the delay-line memory arbiter: s2a port word types,
// arbiter FSM states and requester sides.
package theremin_pkg;

  localparam int PKG_ADDR_W = 19;
  localparam int PKG_DATA_W = 32;

  typedef logic [PKG_ADDR_W-1:0] mem_addr_t;
  typedef logic [PKG_DATA_W-1:0] mem_data_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR       = 2'd1,
    RD_ISSUE = 2'd2,
    RD_WAIT  = 2'd3
  } arb_state_t;

  typedef enum logic {
    SIDE_WR = 1'b0,
    SIDE_RD = 1'b1
  } arb_side_t;

  // Side that gets priority after the given side has been served.
  function automatic arb_side_t other_side(input arb_side_t side);
    return (side == SIDE_WR) ? SIDE_RD : SIDE_WR;
  endfunction

endpackage

// File: rtl/delay_mem_arb_arb2_rr.sv
// Two-way round-robin arbiter: combinational grant while enabled, with the
// priority pointer moving to the opposite side of every grant issued.
module arb2_rr
  import theremin_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic req_wr_i,
  input  logic req_rd_i,
  output logic gnt_wr_o,
  output logic gnt_rd_o
);

  arb_side_t prio_q;

  // Grant one side: the only requester, or the prioritised one on contention.
  always_comb begin
    gnt_wr_o = 1'b0;
    gnt_rd_o = 1'b0;
    if (en_i) begin
      if (req_wr_i && req_rd_i) begin
        if (prio_q == SIDE_WR) begin
          gnt_wr_o = 1'b1;
        end else begin
          gnt_rd_o = 1'b1;
        end
      end else if (req_wr_i) begin
        gnt_wr_o = 1'b1;
      end else if (req_rd_i) begin
        gnt_rd_o = 1'b1;
      end else begin
        gnt_wr_o = 1'b0;
      end
    end else begin
      gnt_wr_o = 1'b0;
    end
  end

  // Hand priority to the side that was not just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= SIDE_WR;
    end else if (gnt_wr_o) begin
      prio_q <= other_side(SIDE_WR);
    end else if (gnt_rd_o) begin
      prio_q <= other_side(SIDE_RD);
    end else begin
      prio_q <= prio_q;
    end
  end

endmodule

// File: rtl/delay_mem_arb.sv
// Sequences delay-line write/read traffic onto the single s2a memory port,
// one access in flight at a time. Writes are fire-and-forget; reads finish
// on mem_readdone. Define DELAY_MEM_TIMEOUT_EN to add a read watchdog that
// aborts RD_WAIT after TIMEOUT_CYC cycles with zero data and rd_timeout.
module delay_mem_arb
  import theremin_pkg::*;
#(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_timeout,
  input  logic              mem_busy,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_writeaddr,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_readaddr,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_readdone
);

  arb_state_t        state_q;
  logic              wr_ack_q;
  logic              rd_ack_q;
  logic              mem_write_q;
  logic              mem_read_q;
  logic              rd_valid_q;
  logic [ADDR_W-1:0] mem_writeaddr_q;
  logic [DATA_W-1:0] mem_writedata_q;
  logic [ADDR_W-1:0] mem_readaddr_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              arb_en_s;
  logic              gnt_wr_s;
  logic              gnt_rd_s;

  // New commands only from IDLE and only while the controller accepts them.
  assign arb_en_s = (state_q == IDLE) && !mem_busy;

  arb2_rr u_arb (
    .clk      (clk),
    .rst_n    (reset_n),
    .en_i     (arb_en_s),
    .req_wr_i (wr_req),
    .req_rd_i (rd_req),
    .gnt_wr_o (gnt_wr_s),
    .gnt_rd_o (gnt_rd_s)
  );

`ifdef DELAY_MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             rd_timeout_q;

  // Read watchdog: clears entering RD_WAIT, counts each RD_WAIT cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
    end else if (state_q == RD_ISSUE) begin
      tmo_cnt_q <= '0;
    end else if (state_q == RD_WAIT) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end else begin
      tmo_cnt_q <= tmo_cnt_q;
    end
  end

  // Timeout strobe; a coincident readdone takes precedence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_timeout_q <= 1'b0;
    end else begin
      rd_timeout_q <= (state_q == RD_WAIT) && !mem_readdone && (tmo_cnt_q == CNT_LAST);
    end
  end

  assign rd_timeout = rd_timeout_q;
`else
  assign rd_timeout = 1'b0;
`endif

  // Arbiter FSM with registered command, ack and read-return outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      wr_ack_q        <= 1'b0;
      rd_ack_q        <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_read_q      <= 1'b0;
      rd_valid_q      <= 1'b0;
      mem_writeaddr_q <= '0;
      mem_writedata_q <= '0;
      mem_readaddr_q  <= '0;
      rd_data_q       <= '0;
    end else begin
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_wr_s) begin
            state_q         <= WR;
            mem_write_q     <= 1'b1;
            wr_ack_q        <= 1'b1;
            mem_writeaddr_q <= wr_addr;
            mem_writedata_q <= wr_data;
          end else if (gnt_rd_s) begin
            state_q        <= RD_ISSUE;
            mem_read_q     <= 1'b1;
            rd_ack_q       <= 1'b1;
            mem_readaddr_q <= rd_addr;
          end else begin
            state_q <= IDLE;
          end
        end
        WR: begin
          state_q <= IDLE;
        end
        RD_ISSUE: begin
          state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          if (mem_readdone) begin
            rd_data_q  <= mem_readdata;
            rd_valid_q <= 1'b1;
            state_q    <= IDLE;
`ifdef DELAY_MEM_TIMEOUT_EN
          end else if (tmo_cnt_q == CNT_LAST) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b1;
            state_q    <= IDLE;
`endif
          end else begin
            state_q <= RD_WAIT;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign wr_ack        = wr_ack_q;
  assign rd_ack        = rd_ack_q;
  assign mem_write     = mem_write_q;
  assign mem_read      = mem_read_q;
  assign rd_valid      = rd_valid_q;
  assign mem_writeaddr = mem_writeaddr_q;
  assign mem_writedata = mem_writedata_q;
  assign mem_readaddr  = mem_readaddr_q;
  assign rd_data       = rd_data_q;

endmodule

// File: tb/tb_delay_mem_arb.sv
// Scoreboard bench for delay_mem_arb: the driver pushes the expected memory
// command / read return sequence, a negedge monitor pops and compares, and a
// memory responder answers reads from the data written so far.
module tb_delay_mem_arb;

  localparam int AW = 19;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int K_W = 0;
  localparam int K_R = 1;
  localparam int K_V = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_req, rd_req, mem_busy, mem_readdone;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, mem_readdata;
  logic          wr_ack, rd_ack, rd_valid, rd_timeout, mem_write, mem_read;
  logic [DW-1:0] rd_data, mem_writedata;
  logic [AW-1:0] mem_writeaddr, mem_readaddr;

  always #5 clk = ~clk;

  delay_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_timeout(rd_timeout),
    .mem_busy(mem_busy),
    .mem_write(mem_write), .mem_writeaddr(mem_writeaddr), .mem_writedata(mem_writedata),
    .mem_read(mem_read), .mem_readaddr(mem_readaddr),
    .mem_readdata(mem_readdata), .mem_readdone(mem_readdone)
  );

  typedef struct {
    int            kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            tmo;
    int            gap;
  } exp_t;

  exp_t          sbq[$];
  exp_t          mon_e;
  bit            mon_ok;
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc_n = 0;
  int            cmd_cnt = 0;
  int            valid_cnt = 0;
  int            last_rd_cyc = 0;
  bit            resp_en = 1'b1;
  int            resp_delay = 3;
  int            stray_cnt = 0;
  logic [DW-1:0] resp_mem[int];
  logic [DW-1:0] model_mem[int];
  bit            prio_rd_m = 1'b0;  // reference round-robin pointer: 0 = write side next

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_data(input logic [AW-1:0] a);
    return {13'h1A5, a} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return model_mem.exists(int'(a)) ? model_mem[int'(a)] : init_data(a);
  endfunction

  function automatic exp_t mk(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input bit t, input int g);
    exp_t e;
    e.kind = k; e.addr = a; e.data = d; e.tmo = t; e.gap = g;
    return e;
  endfunction

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    sbq.push_back(mk(K_W, a, d, 1'b0, 0));
    model_mem[int'(a)] = d;
  endtask

  task automatic push_rd(input logic [AW-1:0] a);
    sbq.push_back(mk(K_R, a, '0, 1'b0, 0));
    sbq.push_back(mk(K_V, '0, model_rd(a), 1'b0, resp_delay + 1));
  endtask

  task automatic sb_pop(input int kind, output exp_t e, output bit ok);
    if (sbq.size() == 0) begin
      n_vec++; n_err++; ok = 1'b0;
      $display("FAIL unexpected_output: got output kind %0d, expected none pending", kind);
    end else begin
      e = sbq.pop_front();
      check("sb_order_kind", kind, e.kind);
      ok = (e.kind == kind);
    end
  endtask

  // Monitor: compare every presented command / read return with the scoreboard.
  always @(negedge clk) begin
    cyc_n++;
    if (reset_n) begin
      if (wr_ack || mem_write) check("wr_ack_with_mem_write", wr_ack, mem_write);
      if (rd_ack || mem_read) check("rd_ack_with_mem_read", rd_ack, mem_read);
      if (rd_timeout) check("rd_timeout_with_rd_valid", rd_valid, 1);
      if (mem_write) begin
        cmd_cnt++;
        resp_mem[int'(mem_writeaddr)] = mem_writedata;
        sb_pop(K_W, mon_e, mon_ok);
        if (mon_ok) begin
          check("mem_writeaddr", mem_writeaddr, mon_e.addr);
          check("mem_writedata", mem_writedata, mon_e.data);
        end
      end
      if (mem_read) begin
        cmd_cnt++;
        last_rd_cyc = cyc_n;
        sb_pop(K_R, mon_e, mon_ok);
        if (mon_ok) check("mem_readaddr", mem_readaddr, mon_e.addr);
      end
      if (rd_valid) begin
        valid_cnt++;
        sb_pop(K_V, mon_e, mon_ok);
        if (mon_ok) begin
          check("rd_data", rd_data, mon_e.data);
          check("rd_timeout", rd_timeout, mon_e.tmo);
          check("read_turnaround_cycles", cyc_n - last_rd_cyc, mon_e.gap);
        end
      end
    end
  end

  // Memory responder: answers each read after resp_delay cycles; also emits stray strobes.
  initial begin : responder
    logic [AW-1:0] ra;
    int            stray_done;
    stray_done   = 0;
    mem_readdone = 1'b0;
    mem_readdata = 32'h0BAD_F00D;
    forever begin
      @(negedge clk);
      if (stray_cnt != stray_done) begin
        stray_done++;
        @(posedge clk); #1;
        mem_readdone = 1'b1; mem_readdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        mem_readdone = 1'b0;
      end else if (reset_n && mem_read && resp_en) begin
        ra = mem_readaddr;
        repeat (resp_delay) @(posedge clk);
        #1;
        mem_readdone = 1'b1;
        mem_readdata = resp_mem.exists(int'(ra)) ? resp_mem[int'(ra)] : init_data(ra);
        @(posedge clk); #1;
        mem_readdone = 1'b0;
        mem_readdata = $urandom;
      end
    end
  end

  // Requester tasks: enter and leave at posedge+1. Latency counts negedges
  // from raising the request to seeing the ack (2 = granted at the first edge).
  task automatic wr_txn(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit chk_lat);
    int c;
    wr_addr = a; wr_data = d; wr_req = 1'b1; c = 0;
    while (1) begin
      @(negedge clk); c++;
      if (wr_ack) break;
      if (c >= 200) begin check("wr_ack_timeout", 0, 1); break; end
    end
    if (chk_lat) check("write_latency", c, 2);
    @(posedge clk); #1;
    wr_req = 1'b0;
  endtask

  task automatic rd_txn(input logic [AW-1:0] a, input bit chk_lat);
    int c;
    int v0;
    v0 = valid_cnt;
    rd_addr = a; rd_req = 1'b1; c = 0;
    while (1) begin
      @(negedge clk); c++;
      if (rd_ack) break;
      if (c >= 200) begin check("rd_ack_timeout", 0, 1); break; end
    end
    if (chk_lat) check("read_issue_latency", c, 2);
    @(posedge clk); #1;
    rd_req = 1'b0;
    c = 0;
    while (valid_cnt == v0 && c < 300) begin @(negedge clk); c++; end
    if (valid_cnt == v0) check("rd_valid_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {wr_ack, rd_ack, rd_valid, rd_timeout, mem_write, mem_read}, 0);
    check({tag, "_mem_writeaddr"}, mem_writeaddr, 0);
    check({tag, "_mem_writedata"}, mem_writedata, 0);
    check({tag, "_mem_readaddr"}, mem_readaddr, 0);
    check({tag, "_rd_data"}, rd_data, 0);
  endtask

  initial begin : global_watchdog
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin : driver
    logic [AW-1:0] wa[4];
    logic [DW-1:0] wd[4];
    logic [AW-1:0] a, ra, last_wa;
    logic [DW-1:0] d;
    int            sc, c0, v0;

    reset_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; mem_busy = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    #3;
    check_all_zero("reset");
    @(posedge clk); #1; reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: single write
    push_wr(19'h00010, 32'hDEADBEEF); prio_rd_m = 1'b1;
    wr_txn(19'h00010, 32'hDEADBEEF, 1'b1);

    // 2: read at top address, readdone 5 cycles after mem_read
    resp_mem[int'(19'h7FFFF)] = 32'h12345678;
    model_mem[int'(19'h7FFFF)] = 32'h12345678;
    resp_delay = 5;
    push_rd(19'h7FFFF); prio_rd_m = 1'b0;
    rd_txn(19'h7FFFF, 1'b1);

    // 3: both requesters held for 4 transactions each, pointer on write side
    resp_delay = 2;
    for (int i = 0; i < 4; i++) begin
      wa[i] = 19'($urandom); wd[i] = $urandom;
      push_wr(wa[i], wd[i]);
      push_rd(wa[i]);
    end
    prio_rd_m = 1'b0;
    fork
      begin for (int i = 0; i < 4; i++) wr_txn(wa[i], wd[i], 1'b0); end
      begin for (int j = 0; j < 4; j++) rd_txn(wa[j], 1'b0); end
    join

    // 4: backpressure holds a write for 10 cycles
    mem_busy = 1'b1; c0 = cmd_cnt;
    push_wr(19'h0ABCD, 32'hCAFE_F00D); prio_rd_m = 1'b1;
    wr_addr = 19'h0ABCD; wr_data = 32'hCAFE_F00D; wr_req = 1'b1;
    repeat (10) @(negedge clk);
    check("busy_blocks_write", cmd_cnt - c0, 0);
    check("busy_blocks_wr_ack", wr_ack, 0);
    @(posedge clk); #1; mem_busy = 1'b0;
    c0 = 0;
    while (1) begin
      @(negedge clk); c0++;
      if (wr_ack) break;
      if (c0 >= 200) begin check("busy_wr_ack_timeout", 0, 1); break; end
    end
    check("write_latency_after_busy", c0, 2);
    @(posedge clk); #1; wr_req = 1'b0;

    // Random mix of lone writes, lone reads and contending pairs
    last_wa = 19'h00010;
    for (int n = 0; n < 40; n++) begin
      sc = $urandom_range(0, 2);
      a = 19'($urandom); d = $urandom;
      ra = ($urandom_range(0, 1) == 1) ? last_wa : 19'($urandom);
      resp_delay = $urandom_range(1, 8);
      if (sc == 0) begin
        push_wr(a, d); prio_rd_m = 1'b1;
        wr_txn(a, d, 1'b1);
      end else if (sc == 1) begin
        push_rd(ra); prio_rd_m = 1'b0;
        rd_txn(ra, 1'b1);
      end else begin
        if (!prio_rd_m) begin push_wr(a, d); push_rd(ra); end
        else begin push_rd(ra); push_wr(a, d); end
        fork
          wr_txn(a, d, 1'b0);
          rd_txn(ra, 1'b0);
        join
      end
      last_wa = a;
    end

`ifdef DELAY_MEM_TIMEOUT_EN
    // 5: watchdog fires with zero data; a late readdone is ignored
    resp_en = 1'b0;
    sbq.push_back(mk(K_R, 19'h01234, '0, 1'b0, 0));
    sbq.push_back(mk(K_V, '0, '0, 1'b1, TO + 1));
    prio_rd_m = 1'b0;
    rd_txn(19'h01234, 1'b1);
    v0 = valid_cnt;
    stray_cnt++;
    repeat (6) @(negedge clk);
    check("late_readdone_ignored", valid_cnt - v0, 0);
    @(posedge clk); #1;
    resp_en = 1'b1;
    // readdone in the same cycle as the timeout: data wins, no timeout flag
    resp_delay = TO;
    push_rd(19'h00010);
    rd_txn(19'h00010, 1'b1);
`endif

    // 6: async reset in RD_WAIT, stray readdone afterwards, then normal write
    resp_en = 1'b0;
    sbq.push_back(mk(K_R, 19'h05555, '0, 1'b0, 0));
    rd_addr = 19'h05555; rd_req = 1'b1;
    c0 = 0;
    while (!rd_ack && c0 < 200) begin @(negedge clk); c0++; end
    check("reset_test_rd_ack", rd_ack, 1);
    @(posedge clk); #1; rd_req = 1'b0;
    repeat (3) @(posedge clk);
    #2; reset_n = 1'b0;
    #1; check_all_zero("async_reset");
    prio_rd_m = 1'b0;
    @(posedge clk); #1; reset_n = 1'b1;
    v0 = valid_cnt;
    stray_cnt++;
    repeat (6) @(negedge clk);
    check("stray_readdone_ignored", valid_cnt - v0, 0);
    check("post_reset_rd_data", rd_data, 0);
    @(posedge clk); #1;
    resp_en = 1'b1;
    push_wr(19'h00777, 32'h0000_7777); prio_rd_m = 1'b1;
    wr_txn(19'h00777, 32'h0000_7777, 1'b1);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
